// File: rtl/dac_pkg.sv
// Shared definitions for the digital alarm clock blocks.
//   - BCD digit limits used by the time-set counter and the time keeper.
//   - hhmm_t: the 16-bit BCD HH:MM word layout {H1,H0,M1,M0}.
//   - hms_t:  the 24-bit BCD HH:MM:SS word layout {HH:MM,S1,S0}.
//   - hhmm_valid(): legal-time check for an HH:MM word.
package dac_pkg;

  localparam logic [3:0] MAX_UNITS          = 4'd9;
  localparam logic [3:0] MAX_MIN_TENS       = 4'd5;
  localparam logic [3:0] MAX_HR_TENS        = 4'd2;
  localparam logic [3:0] MAX_HR_UNITS_AT_20 = 4'd3;

  typedef struct packed {
    logic [3:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } hhmm_t;

  typedef struct packed {
    hhmm_t      hm;
    logic [3:0] s1;
    logic [3:0] s0;
  } hms_t;

  // Hours above 23 are rejected even though each digit is in range.
  function automatic logic hhmm_valid(input hhmm_t t);
    return (t.h1 <= MAX_HR_TENS) && (t.h0 <= MAX_UNITS) &&
           !((t.h1 == MAX_HR_TENS) && (t.h0 > MAX_HR_UNITS_AT_20)) &&
           (t.m1 <= MAX_MIN_TENS) && (t.m0 <= MAX_UNITS);
  endfunction

endpackage

// File: rtl/bcd_hms_next.sv
// Combinational BCD HH:MM:SS incrementer with 23:59:59 -> 00:00:00 wrap.
//   hms_in  : current {HH,MM,SS} (hms_t layout)
//   hms_out : time one second later
module bcd_hms_next
  import dac_pkg::*;
(
  input  logic [23:0] hms_in,
  output logic [23:0] hms_out
);

  hms_t c, n;
  logic c_s1, c_m0, c_m1, c_hr;

  assign c = hms_in;

  always_comb begin
    n    = c;
    // Each carry means "this digit and all below it are wrapping".
    c_s1 = (c.s0 == MAX_UNITS);
    c_m0 = c_s1 && (c.s1 == MAX_MIN_TENS);
    c_m1 = c_m0 && (c.hm.m0 == MAX_UNITS);
    c_hr = c_m1 && (c.hm.m1 == MAX_MIN_TENS);

    n.s0 = c_s1 ? 4'd0 : c.s0 + 4'd1;
    if (c_s1) n.s1 = (c.s1 == MAX_MIN_TENS) ? 4'd0 : c.s1 + 4'd1;
    if (c_m0) n.hm.m0 = (c.hm.m0 == MAX_UNITS) ? 4'd0 : c.hm.m0 + 4'd1;
    if (c_m1) n.hm.m1 = (c.hm.m1 == MAX_MIN_TENS) ? 4'd0 : c.hm.m1 + 4'd1;
    if (c_hr) begin
      if ((c.hm.h1 == MAX_HR_TENS) && (c.hm.h0 == MAX_HR_UNITS_AT_20)) begin
        n.hm.h1 = 4'd0;
        n.hm.h0 = 4'd0;
      end else if (c.hm.h0 == MAX_UNITS) begin
        n.hm.h1 = c.hm.h1 + 4'd1;
        n.hm.h0 = 4'd0;
      end else begin
        n.hm.h0 = c.hm.h0 + 4'd1;
      end
    end
  end

  assign hms_out = n;

endmodule

// File: rtl/bcd_time_keeper.sv
// Running time and alarm register block for the digital alarm clock.
//   clk, reset     : clock, synchronous active-low reset
//   set_data       : BCD HH:MM from the time-set counter
//   load_time      : load set_data into the running time (seconds cleared)
//   load_alarm     : load set_data into the alarm register
//   alarm_en       : alarm armed; low also clears a pending alarm
//   stop_alarm     : clears alarm
//   current_time   : BCD HH:MM       seconds : BCD SS
//   alarm_time     : BCD HH:MM alarm setting
//   one_sec        : pulse in the cycle the advanced time is first visible
//   load_err       : pulse one cycle after a rejected load
//   alarm          : latched alarm indication
module bcd_time_keeper
  import dac_pkg::*;
#(
  parameter int CLK_PER_SEC = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] set_data,
  input  logic        load_time,
  input  logic        load_alarm,
  input  logic        alarm_en,
  input  logic        stop_alarm,
  output logic [15:0] current_time,
  output logic [7:0]  seconds,
  output logic [15:0] alarm_time,
  output logic        one_sec,
  output logic        load_err,
  output logic        alarm
);

  localparam int PW = $clog2(CLK_PER_SEC);
  localparam logic [PW-1:0] TERM = PW'(CLK_PER_SEC - 1);

  logic [PW-1:0] presc;
  logic          tick, set_ok;
  logic [23:0]   hms_nxt;

  assign tick   = (presc == TERM);
  assign set_ok = hhmm_valid(hhmm_t'(set_data));

  bcd_hms_next u_next (
    .hms_in  ({current_time, seconds}),
    .hms_out (hms_nxt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc        <= '0;
      current_time <= '0;
      seconds      <= '0;
      alarm_time   <= '0;
      one_sec      <= 1'b0;
      load_err     <= 1'b0;
      alarm        <= 1'b0;
    end else begin
      // An accepted time load restarts the second and swallows a tick.
      // A rejected one leaves the clock running undisturbed.
      if (load_time && set_ok) begin
        current_time <= set_data;
        seconds      <= 8'h00;
        presc        <= '0;
        one_sec      <= 1'b0;
      end else if (tick) begin
        {current_time, seconds} <= hms_nxt;
        presc        <= '0;
        one_sec      <= 1'b1;
      end else begin
        presc        <= presc + PW'(1);
        one_sec      <= 1'b0;
      end

      if (load_alarm && set_ok) alarm_time <= set_data;

      // Both strobes share set_data, so one validity result covers both.
      load_err <= (load_time || load_alarm) && !set_ok;

      // Match uses registered state so a load never fires the alarm.
      if (stop_alarm || !alarm_en)
        alarm <= 1'b0;
      else if (one_sec && (seconds == 8'h00) && (current_time == alarm_time))
        alarm <= 1'b1;
    end
  end

endmodule
